// File: rtl/riscv_mmio_pkg.sv
// Shared constants for the RISC-V MMIO bridge: register offsets inside the
// 16-byte window and STATUS bit positions.
package riscv_mmio_pkg;

  localparam logic [3:0] OFF_TX     = 4'h0;
  localparam logic [3:0] OFF_RX     = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_TX_EMPTY    = 1;
  localparam int STAT_RX_NONEMPTY = 2;
  localparam int STAT_TX_CNT_LSB  = 8;

  // STATUS reports the TX fill level in an 8-bit field, clamped at 255.
  function automatic logic [7:0] sat_u8(input logic [31:0] i_val);
    return (i_val > 32'd255) ? 8'hFF : i_val[7:0];
  endfunction

endpackage

// File: rtl/mmio_byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy count; used for both the TX and
// RX streams of the MMIO bridge.
module mmio_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: the storage array is deliberately not reset; emptiness is tracked by
  // r_count alone, so stale entries are never observable and the array can map
  // to plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state updates use non-blocking assignment so every register sees
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mmio_bridge.sv
// Routes core loads/stores either to data memory or to a 16-byte MMIO window
// holding TX/RX byte FIFOs and STATUS. Define RISCV_MMIO_RX_EN to build the RX path.
module riscv_mmio_bridge
  import riscv_mmio_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic              core_re,
  input  logic [31:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              data_we,
  output logic [31:0]       data_addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] read_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [31:0]       status
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              w_in_win;
  logic              w_sel_tx;
  logic              w_sel_rx;
  logic              w_sel_status;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [CNT_W-1:0]  w_tx_count;
  logic [7:0]        w_tx_head;
  logic              w_rx_nonempty;
  logic [7:0]        w_rx_rd;
  logic [31:0]       w_status;
  logic [DATA_W-1:0] w_mmio_rd;
  logic              r_rd_mmio;
  logic [DATA_W-1:0] r_rd_data;

  assign w_in_win     = (core_addr[31:4] == MMIO_BASE[31:4]);
  assign w_sel_tx     = w_in_win && (core_addr[3:2] == OFF_TX[3:2]);
  assign w_sel_rx     = w_in_win && (core_addr[3:2] == OFF_RX[3:2]);
  assign w_sel_status = w_in_win && (core_addr[3:2] == OFF_STATUS[3:2]);

  assign data_we   = core_we & ~w_in_win;
  assign data_addr = core_addr;
  assign din       = core_wdata;

  // A store to a full TX FIFO holds the core; it lands on the first free cycle.
  assign core_stall = core_we & w_sel_tx & w_tx_full;
  assign w_tx_push  = core_we & w_sel_tx & ~w_tx_full;
  assign w_tx_pop   = ~w_tx_empty & tx_ready;
  assign tx_valid   = ~w_tx_empty;
  assign tx_data    = w_tx_head;

  mmio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  (core_wdata[7:0]),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

`ifdef RISCV_MMIO_RX_EN
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [7:0]       w_rx_head;
  logic [CNT_W-1:0] w_rx_count_unused;

  // rx_ready is forced low during reset so no byte is accepted into a FIFO being cleared.
  assign rx_ready      = ~rst & ~w_rx_full;
  assign w_rx_push     = rx_valid & rx_ready;
  assign w_rx_pop      = core_re & w_sel_rx & ~w_rx_empty;
  assign w_rx_nonempty = ~w_rx_empty;
  assign w_rx_rd       = w_rx_empty ? 8'h00 : w_rx_head;

  mmio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (rx_data),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count_unused)
  );
`else
  logic w_rx_in_unused;

  assign w_rx_in_unused = ^{rx_data, rx_valid};
  assign rx_ready       = 1'b0;
  assign w_rx_nonempty  = 1'b0;
  assign w_rx_rd        = 8'h00;
`endif

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_status                           = '0;
    w_status[STAT_TX_FULL]             = w_tx_full;
    w_status[STAT_TX_EMPTY]            = w_tx_empty;
    w_status[STAT_RX_NONEMPTY]         = w_rx_nonempty;
    w_status[STAT_TX_CNT_LSB +: 8]     = sat_u8(32'(w_tx_count));
  end

  assign status = w_status;

  always_comb begin
    w_mmio_rd = '0;
    if (w_sel_rx)          w_mmio_rd = DATA_W'(w_rx_rd);
    else if (w_sel_status) w_mmio_rd = DATA_W'(w_status);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_mmio <= 1'b0;
      r_rd_data <= '0;
    end else if (core_re) begin
      r_rd_mmio <= w_in_win;
      r_rd_data <= w_mmio_rd;
    end
  end

  // Memory read data passes straight through, so it is masked while in reset.
  assign core_rdata = rst ? '0 : (r_rd_mmio ? r_rd_data : read_data);

endmodule
